// File: rtl/mac_array_stream.sv
// P-lane signed saturating MAC array: one shared activation times P weights, summed over VEC_LEN beats.
// Latency: a beat accepted at edge e is in the accumulator after edge e+MULT_STAGES+2; results appear at the same edge as the last accumulate.
// Backpressure: in_ready falls after the final beat until out_f is taken; OUT holds while out_ready=0. Define MAC_ARRAY_RELU_EN to apply ReLU to out_f.
module mac_array_stream #(
    parameter int T           = 14,
    parameter int P           = 4,
    parameter int VEC_LEN     = 8,
    parameter int MULT_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [T-1:0] in_x,
    input  logic [P*T-1:0]      in_w,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P*T-1:0]      out_f,
    output logic                busy
);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam int             CW   = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0]  LAST = CW'(VEC_LEN - 1);

    localparam logic signed [T-1:0]   AMAX = {1'b0, {(T-1){1'b1}}};
    localparam logic signed [T-1:0]   AMIN = {1'b1, {(T-1){1'b0}}};
    localparam logic signed [2*T-1:0] PMAX = {{(T+1){1'b0}}, {(T-1){1'b1}}};
    localparam logic signed [2*T-1:0] PMIN = {{(T+1){1'b1}}, {(T-1){1'b0}}};

    function automatic logic signed [2*T-1:0] mul(input logic signed [T-1:0] a,
                                                  input logic signed [T-1:0] b);
        logic signed [2*T-1:0] ae;
        logic signed [2*T-1:0] be;
        ae = {{T{a[T-1]}}, a};
        be = {{T{b[T-1]}}, b};
        return ae * be;
    endfunction

    function automatic logic signed [T-1:0] clamp(input logic signed [2*T-1:0] p);
        if (p > PMAX)      return AMAX;
        else if (p < PMIN) return AMIN;
        else               return p[T-1:0];
    endfunction

    function automatic logic signed [T-1:0] sat_add(input logic signed [T-1:0] a,
                                                    input logic signed [T-1:0] b);
        logic signed [T-1:0] s;
        s = a + b;
        if (a[T-1] && b[T-1] && !s[T-1])        return AMIN;
        else if (!a[T-1] && !b[T-1] && s[T-1])  return AMAX;
        else                                    return s;
    endfunction

    function automatic logic [T-1:0] out_xform(input logic signed [T-1:0] v);
`ifdef MAC_ARRAY_RELU_EN
        return v[T-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [P*T-1:0]          out_f_q, out_f_d;

    logic signed [T-1:0]     x_q;
    logic signed [T-1:0]     w_q   [P];
    logic                    v0_q;
    logic signed [2*T-1:0]   prod_q [MULT_STAGES][P];
    logic [MULT_STAGES-1:0]  mv_q;
    logic signed [T-1:0]     cl_q  [P];
    logic                    cv_q;
    logic signed [T-1:0]     acc_q [P];
    logic signed [T-1:0]     acc_d [P];

    logic accept;
    logic clr;
    logic upstream_empty;

    assign in_ready       = (state_q == ST_ACCUM);
    assign accept         = in_valid && in_ready;
    assign upstream_empty = !v0_q && (mv_q == '0);
    assign out_valid      = out_valid_q;
    assign out_f          = out_f_q;
    assign busy           = (cnt_q != '0) || (state_q != ST_ACCUM);

    // acc_d already contains the product sitting in the clamp stage, so the
    // output copy can happen on the same edge as the final accumulate.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            if (clr)       acc_d[i] = '0;
            else if (cv_q) acc_d[i] = sat_add(acc_q[i], cl_q[i]);
            else           acc_d[i] = acc_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_f_d     = out_f_q;
        clr         = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (upstream_empty) begin
                    for (int i = 0; i < P; i++) out_f_d[i*T +: T] = out_xform(acc_d[i]);
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    clr         = 1'b1;
                    state_d     = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q  <= '0;
            v0_q <= 1'b0;
            mv_q <= '0;
            cv_q <= 1'b0;
            for (int i = 0; i < P; i++) begin
                w_q[i]   <= '0;
                cl_q[i]  <= '0;
                acc_q[i] <= '0;
                for (int s = 0; s < MULT_STAGES; s++) prod_q[s][i] <= '0;
            end
        end else begin
            v0_q <= accept;
            if (accept) x_q <= in_x;
            mv_q[0] <= v0_q;
            for (int s = 1; s < MULT_STAGES; s++) mv_q[s] <= mv_q[s-1];
            cv_q <= mv_q[MULT_STAGES-1];
            for (int i = 0; i < P; i++) begin
                if (accept) w_q[i] <= in_w[i*T +: T];
                prod_q[0][i] <= mul(x_q, w_q[i]);
                for (int s = 1; s < MULT_STAGES; s++) prod_q[s][i] <= prod_q[s-1][i];
                cl_q[i]  <= clamp(prod_q[MULT_STAGES-1][i]);
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mac_array_stream.sv
// Directed stimulus for mac_array_stream (T=14, P=2, VEC_LEN=4, MULT_STAGES=2) with a queue scoreboard.
module tb_mac_array_stream;

    localparam int T  = 14;
    localparam int P  = 2;
    localparam int VL = 4;
    localparam int MS = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [T-1:0] in_x = '0;
    logic [P*T-1:0]      in_w = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [P*T-1:0]      out_f;
    logic                busy;

    mac_array_stream #(.T(T), .P(P), .VEC_LEN(VL), .MULT_STAGES(MS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    l0;
        int    l1;
        string tag;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_acc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int lane(input int i);
        logic signed [T-1:0] v;
        v = out_f[i*T +: T];
        return int'(v);
    endfunction

    // Scoreboard monitor: pops one expected result per output handshake.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got lane0=%0d lane1=%0d, expected no output", lane(0), lane(1));
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.tag, "_lane0"}, lane(0), mon_e.l0);
                chk({mon_e.tag, "_lane1"}, lane(1), mon_e.l1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int l0, input int l1, input string tag);
        exp_t e;
        e.l0 = l0; e.l1 = l1; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic send(input int x, input int w0, input int w1);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end
        in_x     = x[T-1:0];
        in_w     = {w1[T-1:0], w0[T-1:0]};
        in_valid = 1'b1;
        tick();
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    // Returns at the first falling edge where out_valid is high.
    task automatic wait_out(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_out_timeout: out_valid 0, expected 1", tag);
        end
    endtask

    // out_ready high: check latency, drain-time in_ready, and return to idle.
    task automatic finish_vec(input string tag);
        wait_out(tag);
        chk({tag, "_latency"}, cyc - last_acc, MS + 2);
        chk({tag, "_in_ready_out"}, in_ready, 0);
        tick();
        @(negedge clk);
        chk({tag, "_ov_after"}, out_valid, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_f", out_f, 0);
        tick();

        // back-to-back basic vector
        push(24, 12, "basic");
        for (int i = 0; i < VL; i++) send(3, 2, 1);
        @(negedge clk);
        chk("basic_in_ready_drain", in_ready, 0);
        chk("basic_busy_drain", busy, 1);
        chk("basic_ov_drain", out_valid, 0);
        finish_vec("basic");

        // product clamp
        push(8191, -8192, "pclamp");
        send(4, 4096, -4096);
        for (int i = 1; i < VL; i++) send(4, 0, 0);
        finish_vec("pclamp");

        // accumulator saturation
        push(8191, -8192, "asat");
        for (int i = 0; i < VL; i++) send(1, 3000, -3000);
        finish_vec("asat");

        // bubbles plus output backpressure
        out_ready = 1'b0;
        push(24, 12, "bubble");
        for (int i = 0; i < VL; i++) begin
            send(3, 2, 1);
            tick();
            tick();
        end
        wait_out("bubble");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_lane0", lane(0), 24);
            chk("hold_lane1", lane(1), 12);
            chk("hold_in_ready", in_ready, 0);
        end
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("hold_ov_after", out_valid, 0);
        chk("hold_in_ready_after", in_ready, 1);

        // next vector starts from zero
        push(8, -8, "fresh");
        for (int i = 0; i < VL; i++) send(2, 1, -1);
        finish_vec("fresh");

        // reset mid-vector
        send(5, 5, 5);
        send(5, 5, 5);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        tick();
        reset = 1'b1;
        push(4, 4, "postrst");
        for (int i = 0; i < VL; i++) send(1, 1, 1);
        finish_vec("postrst");

        // reset while holding in OUT: result discarded, no handshake
        out_ready = 1'b0;
        for (int i = 0; i < VL; i++) send(2, 3, 3);
        wait_out("outrst");
        tick();
        reset = 1'b0;
        #1;
        chk("outrst_out_valid", out_valid, 0);
        chk("outrst_busy", busy, 0);
        chk("outrst_out_f", out_f, 0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;

        // negative sum through optional ReLU
`ifdef MAC_ARRAY_RELU_EN
        push(0, 7, "relu");
`else
        push(-5, 7, "relu");
`endif
        send(1, -5, 7);
        for (int i = 1; i < VL; i++) send(1, 0, 0);
        finish_vec("relu");

        k = 0;
        while (sbq.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        chk("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
